// File: rtl/shift_cmd_pipe.sv
// Two-stage registered wrapper around an external combinational shifter; result is valid 2 cycles after command accept.
// Valid/ready on both sides with full backpressure; no skid, so in_ready follows out_ready combinationally.
module shift_cmd_pipe #(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in_data,
  input  logic [N-1:0]      in_amt,
  input  logic              in_lr,
  output logic [2**N-1:0]   sh_a,
  output logic [N-1:0]      sh_amt,
  output logic              sh_lr,
  input  logic [2**N-1:0]   sh_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_data,
  output logic [CNT_W-1:0]  op_count,
  output logic              busy
);

  localparam int W = 2**N;

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] amt;
    logic         lr;
  } cmd_t;

  cmd_t s1;
  logic s1_valid;
  logic adv2;
  logic accept;
  logic pop;

  // Stage 2 can take stage 1 whenever it is empty or being drained this cycle.
  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign busy     = s1_valid || out_valid;

  assign sh_a   = s1.data;
  assign sh_amt = s1.amt;
  assign sh_lr  = s1.lr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1       <= '{data: in_data, amt: in_amt, lr: in_lr};
      s1_valid <= 1'b1;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (adv2) begin
      out_data  <= sh_y;
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Counts delivered results; wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/shift_cmd_pipe.md
Name: shift_cmd_pipe

Overview:
- Two-stage registered front/back end for the combinational multi-barrel shifter/reverser.
- Stage 1 accepts shift commands {data, amt, lr} over a valid/ready handshake, registers them, and drives the shifter's a/amt/lr inputs.
- Stage 2 captures the shifter result and presents it downstream over a valid/ready handshake with full backpressure.
- Sustains one command per cycle. Also keeps a wrapping count of completed operations.

Parameters:
- N, 3, log2 of data width. Data width W = 2**N; amt width = N. Must match the attached shifter.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  command valid
- in_ready  output  1  command accepted when in_valid && in_ready
- in_data  input  W  operand to shift
- in_amt  input  N  shift amount, 0..W-1
- in_lr  input  1  direction: 1 = right, 0 = left (shifter convention)
- sh_a  output  W  to shifter a (stage-1 register)
- sh_amt  output  N  to shifter amt (stage-1 register)
- sh_lr  output  1  to shifter lr (stage-1 register)
- sh_y  input  W  combinational result from shifter
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_data  output  W  registered shift result
- op_count  output  CNT_W  number of results delivered (out handshakes)
- busy  output  1  s1_valid || out_valid

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - s1_valid=0, out_valid=0, op_count=0.
  - sh_a, sh_amt, sh_lr and out_data clear to 0.
  - Reset overrides any handshake in the same cycle. In-flight commands are discarded and no output handshake is counted.
- Stage-2 advance: adv2 = s1_valid && (!out_valid || out_ready).
- Stage-1 ready:
  - in_ready = !s1_valid || adv2.
  - This is combinational from out_ready (no skid), and in_ready is not gated by in_valid.
- Stage-1 update each edge:
  - If in_valid && in_ready: load in_data/in_amt/in_lr into sh_a/sh_amt/sh_lr; s1_valid=1.
  - Else if adv2: s1_valid=0.
  - Otherwise hold all stage-1 registers unchanged; sh_* hold stable while s1_valid=1 and stalled.
- Stage-2 update each edge:
  - If adv2: out_data <= sh_y; out_valid=1.
  - Else if out_valid && out_ready: out_valid=0.
  - Otherwise hold. out_data never changes while out_valid=1 && out_ready=0.
- Latency and throughput:
  - A command accepted at edge t appears with out_valid=1 after edge t+1, i.e. 2 cycles after acceptance when there is no backpressure.
  - With out_ready held high, throughput is 1 command/cycle.
- Simultaneous events:
  - Accept into stage 1 and advance stage 1→2 on the same edge is legal; stage 1 takes the new command.
  - Output pop and stage-2 load on the same edge is legal; out_valid stays 1 with new data.
- Full condition: s1_valid=1 and out_valid=1 and out_ready=0 → in_ready=0. Both stages hold. The upstream must keep in_valid and data stable (standard valid/ready rule; not checked by this block).
- Empty condition: busy=0; sh_* retain their last values.
- op_count:
  - Increments by 1 on each edge with out_valid && out_ready.
  - Wraps from 2**CNT_W-1 to 0 with no flag.
- Arithmetic: none in the datapath beyond the counter. The result is whatever the shifter returns (logical shift, zero fill). in_amt=0 returns in_data unchanged.

Test Plan (N=3, external shifter instance attached):
- Reset then single command: in_data=8'hB1, in_amt=3, in_lr=1 accepted at edge t, out_ready=1 → out_valid=1 after edge t+1, out_data=8'h16, op_count=1.
- Left shift: 8'hB1, amt=3, lr=0 → out_data=8'h88. With amt=0 → 8'hB1. With amt=7, lr=1 → 8'h01.
- Back-to-back streaming: 8 commands on consecutive cycles, out_ready=1 → in_ready stays 1, 8 consecutive out_valid cycles in order, op_count=8.
- Backpressure: out_ready=0 while 3 commands are offered → first two are accepted, in_ready falls to 0, out_data holds the first result. Raise out_ready → all three results emerge in order and none are lost or duplicated.
- Reset mid-operation: both stages full with out_ready=0, assert reset one cycle → out_valid=0, s1_valid=0, busy=0, op_count=0. The next command completes normally.
- Counter wrap: preload with 2**CNT_W-1 deliveries (or CNT_W=4 build with 16 deliveries) → op_count returns to 0.
